// File: rtl/uart_tx_tl_if.sv
// TileLink-UL style request (A) and response (D) channel bundles for uart_tx_tl.
// The slave modport is the side that consumes A and produces D.
interface tilelink_a;
  logic [2:0]  a_opcode;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        a_valid;

  modport master (output a_opcode, a_address, a_mask, a_data, a_valid);
  modport slave  (input  a_opcode, a_address, a_mask, a_data, a_valid);
endinterface

interface tilelink_d;
  logic [2:0]  d_opcode;
  logic [31:0] d_data;
  logic        d_error;
  logic        d_valid;

  modport master (input  d_opcode, d_data, d_error, d_valid);
  modport slave  (output d_opcode, d_data, d_error, d_valid);
endinterface

// File: rtl/uart_tx_tl.sv
// Bus-attached UART transmitter: 8-entry TX FIFO, TXDATA/STATUS registers,
// 8N1 framing with a registered, glitch-free serial output.
module uart_tx_tl #(
  parameter logic [31:0] addr_mask      = 32'hF0000000,
  parameter logic [31:0] addr_tag       = 32'h40000000,
  parameter int unsigned clocks_per_bit = 16
) (
  input  logic       clock,
  input  logic       tick_reset_in,
  tilelink_a.slave   tick_tla,
  tilelink_d.slave   bus_tld,
  output logic       serial_tx
);

  localparam logic [15:0] BAUD_RELOAD = 16'(clocks_per_bit - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_baud, w_baud_nxt;
  logic [2:0]  r_bit, w_bit_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic        r_tx, w_tx_nxt;

  logic [7:0]  r_mem [8];
  logic [2:0]  r_wptr, r_rptr;
  logic [3:0]  r_count;

  logic [2:0]  r_d_opcode;
  logic [31:0] r_d_data;
  logic        r_d_error, r_d_valid;

  logic        w_sel, w_is_wr, w_is_rd, w_bad_op, w_reserved;
  logic        w_push_req, w_push, w_pop, w_drop, w_full, w_empty, w_tick;
  logic [1:0]  w_off;
  logic [31:0] w_status;
  logic        w_unused;

  // Request decode
  assign w_sel      = tick_tla.a_valid && !tick_reset_in &&
                      ((tick_tla.a_address & addr_mask) == addr_tag);
  assign w_off      = tick_tla.a_address[3:2];
  assign w_is_wr    = (tick_tla.a_opcode == 3'd0) || (tick_tla.a_opcode == 3'd1);
  assign w_is_rd    = (tick_tla.a_opcode == 3'd4);
  assign w_bad_op   = !(w_is_wr || w_is_rd);
  assign w_reserved = w_off[1];

  assign w_full  = (r_count == 4'd8);
  assign w_empty = (r_count == 4'd0);
  assign w_tick  = (r_baud == 16'd0);

  // A full FIFO still accepts a push when the transmitter pops in the same cycle.
  assign w_push_req = w_sel && w_is_wr && (w_off == 2'd0) && tick_tla.a_mask[0];
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  assign w_status = {25'd0, r_count, w_empty, w_full, (r_state != IDLE)};
  assign w_unused = &{1'b0, tick_tla.a_data[31:8], tick_tla.a_mask[3:1]};

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = w_tick ? 16'd0 : r_baud - 16'd1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_state_nxt = START;
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rptr];
          w_baud_nxt  = BAUD_RELOAD;
        end
      end
      START: begin
        if (w_tick) begin
          w_state_nxt = DATA;
          w_bit_nxt   = 3'd0;
          w_baud_nxt  = BAUD_RELOAD;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_baud_nxt  = BAUD_RELOAD;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          if (!w_empty) begin
            w_state_nxt = START;
            w_pop       = 1'b1;
            w_shift_nxt = r_mem[r_rptr];
            w_baud_nxt  = BAUD_RELOAD;
          end else begin
            w_state_nxt = IDLE;
            w_baud_nxt  = 16'd0;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // The line level is derived from the next state so serial_tx is a plain flop.
    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (tick_reset_in) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (tick_reset_in) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 3'd1;
      if (w_pop)  r_rptr <= r_rptr + 3'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= tick_tla.a_data[7:0];
  end

  always_ff @(posedge clock) begin
    if (tick_reset_in || !w_sel) begin
      r_d_valid  <= 1'b0;
      r_d_opcode <= '0;
      r_d_data   <= '0;
      r_d_error  <= 1'b0;
    end else begin
      r_d_valid  <= 1'b1;
      r_d_opcode <= w_is_rd ? 3'd1 : 3'd0;
      r_d_error  <= w_bad_op || w_reserved || w_drop;
      r_d_data   <= (w_is_rd && (w_off == 2'd1)) ? w_status : '0;
    end
  end

  assign bus_tld.d_valid  = r_d_valid;
  assign bus_tld.d_opcode = r_d_opcode;
  assign bus_tld.d_data   = r_d_data;
  assign bus_tld.d_error  = r_d_error;
  assign serial_tx        = r_tx;

endmodule

// File: tb/tb_uart_tx_tl.sv
// Directed bench for uart_tx_tl at clocks_per_bit=4: bus responses, FIFO
// full/drop behaviour, frame waveforms and reset recovery.
module tb_uart_tx_tl;

  localparam int unsigned CPB = 4;

  logic clock = 1'b0;
  logic tick_reset_in;
  logic serial_tx;

  tilelink_a tla ();
  tilelink_d tld ();

  uart_tx_tl #(
    .addr_mask      (32'hF0000000),
    .addr_tag       (32'h40000000),
    .clocks_per_bit (CPB)
  ) dut (
    .clock         (clock),
    .tick_reset_in (tick_reset_in),
    .tick_tla      (tla.slave),
    .bus_tld       (tld.slave),
    .serial_tx     (serial_tx)
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic        r_dv, r_derr;
  logic [2:0]  r_dop;
  logic [31:0] r_dd;
  logic [79:0] r_wave;
  logic [79:0] r_exp;
  int unsigned n_low;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; presents one request for one cycle and samples the
  // response at the following negedge.
  task automatic bus_req(input logic [2:0] op, input logic [31:0] addr,
                         input logic [3:0] mask, input logic [31:0] data);
    tla.a_opcode  = op;
    tla.a_address = addr;
    tla.a_mask    = mask;
    tla.a_data    = data;
    tla.a_valid   = 1'b1;
    @(negedge clock);
    tla.a_valid = 1'b0;
    r_dv   = tld.d_valid;
    r_dop  = tld.d_opcode;
    r_dd   = tld.d_data;
    r_derr = tld.d_error;
  endtask

  task automatic collect(input int unsigned n);
    r_wave = '0;
    for (int unsigned k = 0; k < n; k++) begin
      r_wave[k] = serial_tx;
      @(negedge clock);
    end
  endtask

  function automatic logic [39:0] frame_bits(input logic [7:0] d);
    logic [39:0] f;
    for (int unsigned k = 0; k < 40; k++) begin
      if (k / CPB == 0)      f[k] = 1'b0;
      else if (k / CPB == 9) f[k] = 1'b1;
      else                   f[k] = d[k / CPB - 1];
    end
    return f;
  endfunction

  initial begin
    tla.a_opcode  = '0;
    tla.a_address = '0;
    tla.a_mask    = '0;
    tla.a_data    = '0;
    tla.a_valid   = 1'b0;
    tick_reset_in = 1'b1;
    repeat (3) @(negedge clock);

    // Reset state, with a STATUS read presented under reset
    check("rst_tx", 80'(serial_tx), 80'd1);
    check("rst_dvalid", 80'(tld.d_valid), 80'd0);
    tla.a_opcode = 3'd4; tla.a_address = 32'h40000004; tla.a_valid = 1'b1;
    @(negedge clock);
    check("rst_req_ignored", 80'({tld.d_valid, tld.d_data}), 80'd0);
    tla.a_valid = 1'b0;
    tick_reset_in = 1'b0;
    @(negedge clock);
    check("rst_req_no_late_resp", 80'(tld.d_valid), 80'd0);

    // STATUS while idle and empty
    bus_req(3'd4, 32'h40000004, 4'hF, 32'd0);
    check("status_idle", 80'({r_dv, r_dop, r_derr, r_dd}), 80'({1'b1, 3'd1, 1'b0, 32'h4}));

    // Single 0x55 frame
    bus_req(3'd0, 32'h40000000, 4'h1, 32'h55);
    check("wr55_resp", 80'({r_dv, r_dop, r_derr, r_dd}), 80'({1'b1, 3'd0, 1'b0, 32'h0}));
    @(negedge clock);
    collect(40);
    check("frame_55", r_wave, 80'(frame_bits(8'h55)));
    check("after_55_idle", 80'(serial_tx), 80'd1);
    bus_req(3'd4, 32'h40000004, 4'hF, 32'd0);
    check("status_after_55", 80'(r_dd), 80'h4);

    // Two contiguous frames
    bus_req(3'd0, 32'h40000000, 4'h1, 32'hA5);
    check("wrA5_err", 80'({r_dv, r_derr}), 80'b10);
    bus_req(3'd1, 32'h40000000, 4'h1, 32'h3C);
    check("wr3C_err", 80'({r_dv, r_derr}), 80'b10);
    collect(80);
    r_exp = {frame_bits(8'h3C), frame_bits(8'hA5)};
    check("frames_A5_3C", r_wave, r_exp);
    check("after_pair_idle", 80'(serial_tx), 80'd1);

    // Ten back-to-back writes: first pops immediately, tenth finds FIFO full
    for (int unsigned i = 0; i < 10; i++) begin
      bus_req(3'd0, 32'h40000000, 4'h1, 32'h10 + 32'(i));
      check($sformatf("burst_wr%0d", i), 80'({r_dv, r_derr}), 80'({1'b1, (i == 9)}));
    end
    bus_req(3'd4, 32'h40000004, 4'hF, 32'd0);
    check("status_full", 80'(r_dd), 80'h43);

    // Reset mid-frame discards the queue and idles the line
    tick_reset_in = 1'b1;
    @(negedge clock);
    check("midframe_rst_tx", 80'(serial_tx), 80'd1);
    tick_reset_in = 1'b0;
    bus_req(3'd4, 32'h40000004, 4'hF, 32'd0);
    check("status_after_rst", 80'(r_dd), 80'h4);
    n_low = 0;
    for (int unsigned k = 0; k < 50; k++) begin
      if (serial_tx !== 1'b1) n_low++;
      @(negedge clock);
    end
    check("line_stays_idle", 80'(n_low), 80'd0);

    // Decode and error cases
    bus_req(3'd0, 32'h80000000, 4'h1, 32'h77);
    check("unselected_no_resp", 80'(r_dv), 80'd0);
    bus_req(3'd4, 32'h40000008, 4'hF, 32'd0);
    check("reserved_get", 80'({r_dv, r_derr, r_dd}), 80'({1'b1, 1'b1, 32'h0}));
    bus_req(3'd2, 32'h40000000, 4'h1, 32'h66);
    check("bad_opcode", 80'({r_dv, r_derr, r_dd}), 80'({1'b1, 1'b1, 32'h0}));
    bus_req(3'd0, 32'h40000000, 4'h0, 32'h99);
    check("mask0_write", 80'({r_dv, r_derr}), 80'b10);
    bus_req(3'd4, 32'h40000000, 4'hF, 32'd0);
    check("txdata_read", 80'({r_dv, r_dop, r_derr, r_dd}), 80'({1'b1, 3'd1, 1'b0, 32'h0}));
    bus_req(3'd4, 32'h40000004, 4'hF, 32'd0);
    check("status_nothing_pushed", 80'(r_dd), 80'h4);
    @(negedge clock);
    check("idle_dvalid_low", 80'({tld.d_valid, tld.d_data}), 80'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
